// File: rtl/immgen_pkg.sv
// Shared opcode constants and the immediate format code used by the decode-stage immediate
// generator.
package immgen_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_CALCI   = 7'b0010011;
  localparam logic [6:0] OPC_CALC    = 7'b0110011;
  localparam logic [6:0] OPC_FLOAD   = 7'b0000111;
  localparam logic [6:0] OPC_FSTORE  = 7'b0100111;
  localparam logic [6:0] OPC_F       = 7'b1010011;
  localparam logic [6:0] OPC_FBRANCH = 7'b1100001;
  localparam logic [6:0] OPC_VLW     = 7'b1000000;
  localparam logic [6:0] OPC_VSW     = 7'b1000010;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_R    = 3'd6
  } fmt_t;

endpackage

// File: rtl/immgen_lane.sv
// Combinational single-lane immediate extractor and format classifier.
module immgen_lane
  import immgen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic               mask,
  output logic [XLEN-1:0]    imm,
  output fmt_t               fmt,
  output logic               illegal
);

  // Every format fits in 32 bits; widening to XLEN is a pure sign extension of bit 31.
  logic [31:0] imm32;

  always_comb begin
    imm32   = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    if (mask) begin
      case (instr[6:0])
        OPC_LUI, OPC_AUIPC: begin
          imm32 = {instr[31:12], 12'b0};
          fmt   = FMT_U;
        end
        OPC_JAL: begin
          imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
          fmt   = FMT_J;
        end
        OPC_JALR, OPC_LOAD, OPC_CALCI, OPC_FLOAD, OPC_VLW, OPC_VSW: begin
          imm32 = {{20{instr[31]}}, instr[31:20]};
          fmt   = FMT_I;
        end
        OPC_STORE, OPC_FSTORE: begin
          imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
          fmt   = FMT_S;
        end
        OPC_BRANCH, OPC_FBRANCH: begin
          imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
          fmt   = FMT_B;
        end
        OPC_CALC, OPC_F: begin
          fmt = FMT_R;
        end
        default: begin
          illegal = 1'b1;
        end
      endcase
    end
  end

  if (XLEN > 32) begin : g_wide
    assign imm = {{(XLEN - 32){imm32[31]}}, imm32};
  end else begin : g_narrow
    assign imm = imm32[XLEN-1:0];
  end

endmodule

// File: rtl/immgen_pipe.sv
// Multi-lane immediate generator with a registered output stage and a one-entry skid buffer
// so the input keeps full throughput under back-pressure.
module immgen_pipe
  import immgen_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned XLEN  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        in_mask,
  input  logic [LANES*32-1:0]     in_instr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_mask,
  output logic [LANES*XLEN-1:0]   out_imm,
  output logic [LANES*3-1:0]      out_fmt,
  output logic [LANES-1:0]        out_illegal
);

  // Payload layout: {mask, imm, fmt, illegal}, matching the out_* concatenation below.
  localparam int unsigned PW = LANES * (XLEN + 5);

  logic [LANES*XLEN-1:0] dec_imm;
  logic [LANES*3-1:0]    dec_fmt;
  logic [LANES-1:0]      dec_ill;
  fmt_t                  lane_fmt [LANES];
  logic [PW-1:0]         in_data;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    immgen_lane #(
      .XLEN(XLEN)
    ) u_lane (
      .instr  (in_instr[32*i +: 32]),
      .mask   (in_mask[i]),
      .imm    (dec_imm[XLEN*i +: XLEN]),
      .fmt    (lane_fmt[i]),
      .illegal(dec_ill[i])
    );
    assign dec_fmt[3*i +: 3] = lane_fmt[i];
  end

  assign in_data = {in_mask, dec_imm, dec_fmt, dec_ill};

  logic          out_valid_q, out_valid_d;
  logic [PW-1:0] out_data_q, out_data_d;
  logic          skid_valid_q, skid_valid_d;
  logic [PW-1:0] skid_data_q, skid_data_d;
  logic          in_ready_q, in_ready_d;
  logic          accept, consume;

  assign accept  = in_valid & in_ready_q;
  assign consume = out_valid_q & out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || consume) begin
      // in_ready is low whenever the skid is full, so skid drain and accept never collide.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign {out_mask, out_imm, out_fmt, out_illegal} = out_data_q;

endmodule

// File: tb/tb_immgen_pipe.sv
// Bench for immgen_pipe: directed decode, back-pressure, flush and reset scenarios plus a
// randomized run against a queue-based reference model, on XLEN=32 and XLEN=64 instances.
module tb_immgen_pipe;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [1:0]   in_mask = 2'b00;
  logic [63:0]  in_instr = '0;

  logic         v32, rdy32, v64, rdy64;
  logic [1:0]   mask32, mask64, ill32, ill64;
  logic [63:0]  imm32;
  logic [127:0] imm64;
  logic [5:0]   fmt32, fmt64;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0]   mask;
    logic [127:0] imm;
    logic [5:0]   fmt;
    logic [1:0]   ill;
  } exp_t;

  always #5 clk = ~clk;

  immgen_pipe #(.LANES(2), .XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_mask(in_mask), .in_instr(in_instr), .out_valid(v32), .out_ready(out_ready),
    .out_mask(mask32), .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32)
  );

  immgen_pipe #(.LANES(2), .XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_mask(in_mask), .in_instr(in_instr), .out_valid(v64), .out_ready(out_ready),
    .out_mask(mask64), .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64)
  );

  // Reference: immediate as a signed integer built from the instruction fields.
  function automatic void ref_lane(input logic [31:0] ins, input logic m,
                                   output logic [63:0] imm, output logic [2:0] fmt,
                                   output logic ill);
    longint v;
    v = 0;
    imm = '0;
    fmt = 3'd0;
    ill = 1'b0;
    if (m) begin
      case (ins[6:0])
        7'h37, 7'h17: begin v = longint'($signed(ins[31:12])) * 4096; fmt = 3'd4; end
        7'h6F: begin
          v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) * 2;
          fmt = 3'd5;
        end
        7'h67, 7'h03, 7'h13, 7'h07, 7'h40, 7'h42: begin
          v = longint'($signed(ins[31:20]));
          fmt = 3'd1;
        end
        7'h23, 7'h27: begin v = longint'($signed({ins[31:25], ins[11:7]})); fmt = 3'd2; end
        7'h63, 7'h61: begin
          v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) * 2;
          fmt = 3'd3;
        end
        7'h33, 7'h53: fmt = 3'd6;
        default: ill = 1'b1;
      endcase
      imm = 64'(v);
    end
  endfunction

  function automatic exp_t model(input logic [1:0] m, input logic [63:0] ins);
    exp_t e;
    logic [63:0] imm;
    logic [2:0] f;
    logic il;
    e = '0;
    e.mask = m;
    for (int l = 0; l < 2; l++) begin
      ref_lane(ins[32*l +: 32], m[l], imm, f, il);
      e.imm[64*l +: 64] = imm;
      e.fmt[3*l +: 3] = f;
      e.ill[l] = il;
    end
    return e;
  endfunction

  function automatic logic [31:0] tag_instr(input int t);
    return {12'(t), 5'd0, 3'd0, 5'd0, 7'h13};
  endfunction

  logic [6:0] ops [16] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13,
                           7'h33, 7'h07, 7'h27, 7'h53, 7'h61, 7'h40, 7'h42, 7'h7F};

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 3) != 0) r[6:0] = ops[$urandom_range(0, 15)];
    return r;
  endfunction

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++;
    if (v32 !== 1'b0 || v64 !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b%b exp=00", v32, v64);
    end
    checks++;
    if (rdy32 !== 1'b0 || rdy64 !== 1'b0) begin
      failures++; $display("FAIL reset_in_ready got=%b%b exp=00", rdy32, rdy64);
    end
    checks++;
    if (imm32 !== '0 || imm64 !== '0 || mask32 !== 2'b00 || fmt32 !== 6'd0 ||
        ill32 !== 2'b00 || fmt64 !== 6'd0) begin
      failures++;
      $display("FAIL reset_out_data imm=%h mask=%b fmt=%h ill=%b exp=0", imm32, mask32, fmt32,
               ill32);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (rdy32 !== 1'b0) begin
      failures++; $display("FAIL reset_ready_before_edge got=%b exp=0", rdy32);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rdy32 !== 1'b1 || rdy64 !== 1'b1) begin
      failures++; $display("FAIL reset_ready_after_edge got=%b%b exp=11", rdy32, rdy64);
    end
  endtask

  task automatic test_decode();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_mask = 2'b11;
    in_instr = {32'h0040006F, 32'hFFF00093};
    @(posedge clk); #1;
    checks++;
    if (v32 !== 1'b1 || imm32 !== {32'h00000004, 32'hFFFFFFFF} || fmt32 !== {3'd5, 3'd1} ||
        ill32 !== 2'b00 || mask32 !== 2'b11) begin
      failures++;
      $display("FAIL dec_addi_jal v=%b imm=%h fmt=%h ill=%b exp v=1 imm=00000004ffffffff fmt=29 ill=00",
               v32, imm32, fmt32, ill32);
    end
    checks++;
    if (imm64 !== {64'h4, 64'hFFFFFFFFFFFFFFFF}) begin
      failures++; $display("FAIL dec_addi_jal_64 imm=%h", imm64);
    end
    in_instr = {32'h0000007F, 32'hFE000EE3};
    @(posedge clk); #1;
    checks++;
    if (imm32 !== {32'h0, 32'hFFFFFFFC} || fmt32 !== {3'd0, 3'd3} || ill32 !== 2'b10) begin
      failures++;
      $display("FAIL dec_branch_illegal imm=%h fmt=%h ill=%b exp imm=00000000fffffffc fmt=03 ill=10",
               imm32, fmt32, ill32);
    end
    in_mask = 2'b01;
    @(posedge clk); #1;
    checks++;
    if (imm32 !== {32'h0, 32'hFFFFFFFC} || fmt32 !== {3'd0, 3'd3} || ill32 !== 2'b00 ||
        mask32 !== 2'b01) begin
      failures++;
      $display("FAIL dec_branch_masked imm=%h fmt=%h ill=%b mask=%b exp ill=00 mask=01", imm32,
               fmt32, ill32, mask32);
    end
    in_mask = 2'b11;
    in_instr = {32'hFE002C23, 32'h800002B7};
    @(posedge clk); #1;
    checks++;
    if (imm64 !== {64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFF80000000} || fmt64 !== {3'd2, 3'd4}) begin
      failures++;
      $display("FAIL dec_lui_sw_64 imm=%h fmt=%h exp imm=fffffffffffffff8ffffffff80000000 fmt=14",
               imm64, fmt64);
    end
    checks++;
    if (imm32 !== {32'hFFFFFFF8, 32'h80000000}) begin
      failures++; $display("FAIL dec_lui_sw_32 imm=%h exp=fffffff880000000", imm32);
    end
    in_mask = 2'b00;
    @(posedge clk); #1;
    checks++;
    if (v32 !== 1'b1 || mask32 !== 2'b00 || imm32 !== '0 || fmt32 !== 6'd0 || ill32 !== 2'b00)
    begin
      failures++;
      $display("FAIL dec_blank v=%b mask=%b imm=%h fmt=%h ill=%b exp v=1 all zero", v32, mask32,
               imm32, fmt32, ill32);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (v32 !== 1'b0) begin
      failures++; $display("FAIL dec_idle_valid got=%b exp=0", v32);
    end
  endtask

  task automatic test_backpressure();
    int tag;
    int got [$];
    tag = 0;
    out_ready = 1'b0;
    in_mask = 2'b01;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_instr = {32'h0, tag_instr(tag)};
      @(negedge clk);
      if (rdy32) tag++;
      @(posedge clk); #1;
    end
    checks++;
    if (v32 !== 1'b1 || imm32[31:0] !== 32'd0 || rdy32 !== 1'b0 || tag != 2) begin
      failures++;
      $display("FAIL bp_hold v=%b imm=%h rdy=%b accepted=%0d exp v=1 imm=0 rdy=0 accepted=2",
               v32, imm32[31:0], rdy32, tag);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (tag < 4);
      in_instr = {32'h0, tag_instr(tag)};
      @(negedge clk);
      if (v32) got.push_back(int'(imm32[31:0]));
      if (in_valid && rdy32) tag++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (got.size() != 4) begin
      failures++; $display("FAIL bp_count got=%0d exp=4", got.size());
    end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      checks++;
      if (got[i] != i) begin
        failures++; $display("FAIL bp_order idx=%0d got=%0d exp=%0d", i, got[i], i);
      end
    end
  endtask

  task automatic test_flush();
    int seen;
    out_ready = 1'b0;
    in_mask = 2'b01;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1;
      in_instr = {32'h0, tag_instr(10 + c)};
      @(posedge clk); #1;
    end
    checks++;
    if (v32 !== 1'b1 || rdy32 !== 1'b0) begin
      failures++; $display("FAIL flush_setup v=%b rdy=%b exp v=1 rdy=0", v32, rdy32);
    end
    flush = 1'b1;
    in_instr = {32'h0, tag_instr(12)};
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (v32 !== 1'b0 || rdy32 !== 1'b1 || v64 !== 1'b0) begin
      failures++; $display("FAIL flush_full v=%b rdy=%b exp v=0 rdy=1", v32, rdy32);
    end
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (v32) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL flush_no_leak outputs=%0d exp=0", seen);
    end
    in_valid = 1'b1;
    flush = 1'b1;
    in_instr = {32'h0, tag_instr(13)};
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (v32 !== 1'b0 || rdy32 !== 1'b1) begin
      failures++; $display("FAIL flush_accept_drop v=%b rdy=%b exp v=0 rdy=1", v32, rdy32);
    end
  endtask

  task automatic test_reset_midstream();
    int seen;
    out_ready = 1'b0;
    in_mask = 2'b11;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1;
      in_instr = {tag_instr(20 + c), tag_instr(30 + c)};
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (v32 !== 1'b1 || rdy32 !== 1'b0) begin
      failures++; $display("FAIL rst_mid_setup v=%b rdy=%b exp v=1 rdy=0", v32, rdy32);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (v32 !== 1'b0 || rdy32 !== 1'b0 || imm32 !== '0 || mask32 !== 2'b00 ||
        fmt32 !== 6'd0 || v64 !== 1'b0 || imm64 !== '0) begin
      failures++;
      $display("FAIL rst_mid_async v=%b rdy=%b imm=%h mask=%b fmt=%h exp all zero", v32, rdy32,
               imm32, mask32, fmt32);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rdy32 !== 1'b1 || v32 !== 1'b0) begin
      failures++; $display("FAIL rst_mid_release rdy=%b v=%b exp rdy=1 v=0", rdy32, v32);
    end
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (v32) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL rst_mid_skid_cleared outputs=%0d exp=0", seen);
    end
  endtask

  task automatic test_random();
    exp_t q [$];
    exp_t e;
    for (int i = 0; i < 420; i++) begin
      if (i < 400) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_mask = 2'($urandom_range(0, 3));
        in_instr = {rand_instr(), rand_instr()};
        out_ready = ($urandom_range(0, 3) != 0);
        flush = ($urandom_range(0, 31) == 0);
      end else begin
        in_valid = 1'b0;
        out_ready = 1'b1;
        flush = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (v32 !== v64 || rdy32 !== rdy64) begin
        failures++;
        $display("FAIL rand_lockstep cyc=%0d v=%b/%b rdy=%b/%b", i, v32, v64, rdy32, rdy64);
      end
      if (v32 && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL rand_spurious cyc=%0d imm=%h exp no output", i, imm32);
        end else begin
          e = q.pop_front();
          if (mask32 !== e.mask || imm32 !== {e.imm[95:64], e.imm[31:0]} ||
              fmt32 !== e.fmt || ill32 !== e.ill || imm64 !== e.imm || fmt64 !== e.fmt ||
              ill64 !== e.ill || mask64 !== e.mask) begin
            failures++;
            $display("FAIL rand_data cyc=%0d mask=%b imm=%h fmt=%h ill=%b exp mask=%b imm=%h fmt=%h ill=%b",
                     i, mask64, imm64, fmt64, ill64, e.mask, e.imm, e.fmt, e.ill);
          end
        end
      end
      if (flush) q.delete();
      else if (in_valid && rdy32) q.push_back(model(in_mask, in_instr));
      @(posedge clk); #1;
    end
    checks++;
    if (q.size() != 0) begin
      failures++; $display("FAIL rand_drain pending=%0d exp=0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
